// File: rtl/floor_pkg.sv
// Shared definitions for the floor scroll scheduler and its helpers.
//   fsm_state_e : scheduler states (IDLE, RUN, HOLD, DONE)
//   SCREEN_H    : visible lines; a floor wraps past SCREEN_H-1
//   FLOOR_CNT   : number of floors handled by the datapath
//   X_STEP      : pixel pitch of spawn slots
//   END_GAP     : default elapsed-tick count at which scrolling ends
//   LFSR_TAPS   : feedback mask for the 8-bit Fibonacci LFSR (taps 8,6,5,4)
package floor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } fsm_state_e;

  localparam int unsigned SCREEN_H  = 480;
  localparam int unsigned FLOOR_CNT = 8;
  localparam int unsigned X_STEP    = 40;
  localparam int unsigned END_GAP   = 320;

  // Bits 7,5,4,3 correspond to taps 8,6,5,4.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/floor_scroll_ctrl_if.sv
// Control/status bundle between the game datapath and the scroll scheduler.
//   master : datapath side; drives start, hit_ceiling, vblank, spawn_req
//            and observes step, commit, spawn_x, time_gap, level, busy
//   slave  : scheduler side (floor_scroll_ctrl)
interface floor_scroll_ctrl_if;
  logic       start;
  logic       hit_ceiling;
  logic       vblank;
  logic       spawn_req;
  logic       step;
  logic       commit;
  logic [9:0] spawn_x;
  logic [8:0] time_gap;
  logic [1:0] level;
  logic       busy;

  modport master (
    output start, hit_ceiling, vblank, spawn_req,
    input  step, commit, spawn_x, time_gap, level, busy
  );

  modport slave (
    input  start, hit_ceiling, vblank, spawn_req,
    output step, commit, spawn_x, time_gap, level, busy
  );
endinterface

// File: rtl/floor_lfsr.sv
// Fibonacci LFSR with advance enable and reset seed.
//   clk   : clock
//   rst   : synchronous active-high reset, loads SEED
//   adv_i : shift one position when high
//   q_o   : low OUT_W bits of the register
// SEED must be nonzero or the register locks at zero.
module floor_lfsr #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = floor_pkg::LFSR_TAPS,
  parameter logic [WIDTH-1:0] SEED  = 8'hA5,
  parameter int unsigned      OUT_W = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv_i,
  output logic [OUT_W-1:0] q_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/floor_scroll_ctrl.sv
// Scroll scheduler for the floor position generator.
//   clk, rst        : clock, synchronous active-high reset
//   bus.start       : one-cycle pulse, (re)starts a game
//   bus.hit_ceiling : 1 = scrolling allowed, 0 = hold
//   bus.vblank      : VGA vertical blank
//   bus.spawn_req   : floor wrapped; advance spawn position generator
//   bus.step        : one-cycle pulse, move floors down 1 px
//   bus.commit      : one-cycle pulse, copy shadow positions to display
//   bus.spawn_x     : spawn x = lfsr[3:0] * X_STEP
//   bus.time_gap    : elapsed base ticks, saturating at NUM_LEVELS*LEVEL_TICKS
//   bus.level       : time_gap / LEVEL_TICKS, clamped to NUM_LEVELS-1
//   bus.busy        : high in RUN and HOLD
module floor_scroll_ctrl #(
  parameter int unsigned TICK_DIV    = 100000,
  parameter int unsigned LEVEL_TICKS = 80,
  parameter int unsigned NUM_LEVELS  = 4,
  parameter int unsigned X_STEP      = 40,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  floor_scroll_ctrl_if.slave  bus
);
  import floor_pkg::*;

  localparam int unsigned PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [8:0]  END_TG     = 9'(NUM_LEVELS * LEVEL_TICKS);

  fsm_state_e    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [8:0]    tg_q, tg_d;
  logic          step_q, step_d;
  logic          pending_q, pending_d;
  logic          fired_q, fired_d;
  logic          tick;
  logic          commit;
  logic [1:0]    level_c;
  logic [2:0]    cad_mask;
  logic [3:0]    lfsr_lo;

  // Level: highest threshold reached, which also clamps at NUM_LEVELS-1.
  always_comb begin
    level_c = '0;
    for (int unsigned i = 1; i < NUM_LEVELS; i++) begin
      if (tg_q >= 9'(i * LEVEL_TICKS)) begin
        level_c = 2'(i);
      end
    end
  end

  always_comb begin
    case (level_c)
      2'd0:    cad_mask = 3'b000;
      2'd1:    cad_mask = 3'b001;
      2'd2:    cad_mask = 3'b011;
      default: cad_mask = 3'b111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tg_d    = tg_q;
    tick    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          presc_d = '0;
          tg_d    = '0;
        end
      end
      ST_RUN: begin
        if (bus.start) begin
          presc_d = '0;
          tg_d    = '0;
        end else if (tg_q == END_TG) begin
          state_d = ST_DONE;
        end else if (!bus.hit_ceiling) begin
          state_d = ST_HOLD;
        end else if (presc_q == PRESC_LAST) begin
          // tg_q < END_TG here, so the increment cannot pass the limit.
          presc_d = '0;
          tick    = 1'b1;
          tg_d    = tg_q + 9'd1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      ST_HOLD: begin
        if (bus.start) begin
          state_d = ST_RUN;
          presc_d = '0;
          tg_d    = '0;
        end else if (bus.hit_ceiling) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Cadence uses the pre-increment count and its level.
  assign step_d = tick && ((tg_q[2:0] & cad_mask) == 3'b000);

  // One commit per vblank window; fired_q blocks repeats until vblank drops.
  assign commit    = bus.vblank && pending_q && !fired_q;
  assign pending_d = step_q || (pending_q && !commit);
  assign fired_d   = bus.vblank && (fired_q || commit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      tg_q      <= '0;
      step_q    <= 1'b0;
      pending_q <= 1'b0;
      fired_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      tg_q      <= tg_d;
      step_q    <= step_d;
      pending_q <= pending_d;
      fired_q   <= fired_d;
    end
  end

  floor_lfsr #(
    .WIDTH (8),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED),
    .OUT_W (4)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv_i (bus.spawn_req),
    .q_o   (lfsr_lo)
  );

  assign bus.spawn_x  = 10'(lfsr_lo) * 10'(X_STEP);
  assign bus.step     = step_q;
  assign bus.commit   = commit;
  assign bus.time_gap = tg_q;
  assign bus.level    = level_c;
  assign bus.busy     = (state_q == ST_RUN) || (state_q == ST_HOLD);

endmodule
